// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship repair bank: state encodings and default sizing.
// No logic; constants and types only.
// Imported by the per-channel FSM and by the bank top level.
package nexys_starship_pkg;

  // One-hot channel state encodings
  localparam logic [2:0] ST_INIT    = 3'b001;
  localparam logic [2:0] ST_WORKING = 3'b010;
  localparam logic [2:0] ST_REPAIR  = 3'b100;

  // Default bank sizing
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_COMBO_W = 4;
  localparam int DEF_TIMEOUT = 1000;

  typedef enum logic [2:0] {
    S_INIT    = ST_INIT,
    S_WORKING = ST_WORKING,
    S_REPAIR  = ST_REPAIR
  } ch_state_e;

endpackage

// File: rtl/nexys_starship_repair_ch.sv
// One ship subsystem: INIT/WORKING/REPAIR FSM, latched repair combo, repair timer, sticky fail flag.
// Latency: every output is registered and reflects the inputs sampled on the previous rising edge.
// Backpressure: none; strobes are acted on in the cycle they are sampled and never held off.
module nexys_starship_repair_ch
  import nexys_starship_pkg::*;
#(
  parameter int COMBO_W = DEF_COMBO_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               i_play,
  input  logic               i_gameover,
  input  logic               i_break,
  input  logic [COMBO_W-1:0] i_random_hex,
  input  logic [COMBO_W-1:0] i_hex_combo,
  input  logic               i_submit,
  input  logic               i_master,
  output logic [2:0]         o_state,
  output logic [COMBO_W-1:0] o_combo,
  output logic               o_fail,
  output logic               o_wrong
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  ch_state_e          r_state;
  logic [COMBO_W-1:0] r_combo;
  logic [TW-1:0]      r_timer;
  logic               r_fail;
  logic               r_wrong;
  logic               w_repaired;

  // A channel is repaired by the master strobe or by a matching submission aimed at it
  assign w_repaired = i_master || (i_submit && (i_hex_combo == r_combo));

  // Channel FSM with combo latch, repair timer and sticky fail; gameover overrides everything
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_INIT;
      r_combo <= '0;
      r_timer <= '0;
      r_fail  <= 1'b0;
      r_wrong <= 1'b0;
    end else begin
      r_wrong <= 1'b0;
      if (i_gameover) begin
        r_state <= S_INIT;
        r_combo <= '0;
        r_timer <= '0;
        r_fail  <= 1'b0;
      end else begin
        case (r_state)
          S_INIT: begin
            r_combo <= '0;
            r_timer <= '0;
            r_fail  <= 1'b0;
            if (i_play) r_state <= S_WORKING;
          end
          S_WORKING: begin
            if (i_break) begin
              r_state <= S_REPAIR;
              r_combo <= i_random_hex;
              r_timer <= '0;
            end
          end
          S_REPAIR: begin
            if (w_repaired) begin
              // Repair beats a simultaneous timeout: fail is left as it was
              r_state <= S_WORKING;
            end else begin
              if (i_submit) r_wrong <= 1'b1;
              // Timer saturates at TIMEOUT-1 so it never wraps while the channel sits broken
              if (r_timer != TW'(TIMEOUT - 1)) r_timer <= r_timer + TW'(1);
              if (r_timer == TW'(TIMEOUT - 2)) r_fail <= 1'b1;
            end
          end
          default: begin
            // Corrupted one-hot state falls back to a clean INIT
            r_state <= S_INIT;
            r_combo <= '0;
            r_timer <= '0;
            r_fail  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_state = r_state;
  assign o_combo = r_combo;
  assign o_fail  = r_fail;
  assign o_wrong = r_wrong;

endmodule

// File: rtl/nexys_starship_repair_bank.sv
// Bank of NUM_CH repair channels: submit decode, master-repair fan-out, wrong-attempt merge, broken count.
// Latency: state outputs one edge after the triggering inputs; broken_count is combinational from broken.
// Backpressure: none; all strobes are single-cycle events consumed immediately.
module nexys_starship_repair_bank
  import nexys_starship_pkg::*;
#(
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int COMBO_W = DEF_COMBO_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = $clog2(NUM_CH + 1)
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       play_flag,
  input  logic                       gameover_ctrl,
  input  logic [NUM_CH-1:0]          break_req,
  input  logic [COMBO_W-1:0]         random_hex,
  input  logic [COMBO_W-1:0]         hex_combo,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       BtnU,
  input  logic                       BtnR,
  output logic [NUM_CH-1:0]          broken,
  output logic [NUM_CH*COMBO_W-1:0]  combo,
  output logic [NUM_CH-1:0]          fail,
  output logic                       wrong_attempt,
  output logic [CNT_W-1:0]           broken_count,
  output logic [NUM_CH-1:0]          q_Init,
  output logic [NUM_CH-1:0]          q_Working,
  output logic [NUM_CH-1:0]          q_Repair
);

  logic [NUM_CH-1:0] w_submit;
  logic [NUM_CH-1:0] w_wrong;
  logic [2:0]        w_state [NUM_CH];
  logic [CNT_W-1:0]  w_cnt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Out-of-range sel values match no channel, so such submissions vanish
    assign w_submit[g] = BtnU && (sel == SEL_W'(g));

    nexys_starship_repair_ch #(
      .COMBO_W (COMBO_W),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .i_play       (play_flag),
      .i_gameover   (gameover_ctrl),
      .i_break      (break_req[g]),
      .i_random_hex (random_hex),
      .i_hex_combo  (hex_combo),
      .i_submit     (w_submit[g]),
      .i_master     (BtnR),
      .o_state      (w_state[g]),
      .o_combo      (combo[g*COMBO_W +: COMBO_W]),
      .o_fail       (fail[g]),
      .o_wrong      (w_wrong[g])
    );

    assign q_Init[g]    = w_state[g][0];
    assign q_Working[g] = w_state[g][1];
    assign q_Repair[g]  = w_state[g][2];
    assign broken[g]    = w_state[g][2];
  end

  assign wrong_attempt = |w_wrong;

  // Population count of the registered broken bits
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) w_cnt = w_cnt + CNT_W'(broken[k]);
  end

  assign broken_count = w_cnt;

endmodule

// File: tb/tb_nexys_starship_repair_bank.sv
// Bench for nexys_starship_repair_bank: directed scenarios then randomized traffic.
// Expected values come from a per-channel behavioural model evaluated once per rising edge.
module tb_nexys_starship_repair_bank;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int TO  = 8;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            play_flag, gameover_ctrl, BtnU, BtnR;
  logic [NCH-1:0]  break_req;
  logic [CW-1:0]   random_hex, hex_combo;
  logic [1:0]      sel;
  logic [NCH-1:0]  broken, fail, q_Init, q_Working, q_Repair;
  logic [NCH*CW-1:0] combo;
  logic            wrong_attempt;
  logic [2:0]      broken_count;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = INIT, 1 = WORKING, 2 = REPAIR
  int          m_st   [NCH];
  logic [CW-1:0] m_combo[NCH];
  int          m_age  [NCH];
  bit          m_fail [NCH];
  bit          m_wrong;

  nexys_starship_repair_bank #(.NUM_CH(NCH), .COMBO_W(CW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .break_req(break_req), .random_hex(random_hex), .hex_combo(hex_combo), .sel(sel),
    .BtnU(BtnU), .BtnR(BtnR), .broken(broken), .combo(combo), .fail(fail),
    .wrong_attempt(wrong_attempt), .broken_count(broken_count),
    .q_Init(q_Init), .q_Working(q_Working), .q_Repair(q_Repair)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = 0; m_combo[c] = '0; m_age[c] = 0; m_fail[c] = 0;
    end
    m_wrong = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied
  task automatic model_edge();
    bit w;
    w = 0;
    for (int c = 0; c < NCH; c++) begin
      if (gameover_ctrl) begin
        m_st[c] = 0; m_combo[c] = '0; m_fail[c] = 0; m_age[c] = 0;
      end else if (m_st[c] == 0) begin
        m_combo[c] = '0; m_fail[c] = 0;
        if (play_flag) m_st[c] = 1;
      end else if (m_st[c] == 1) begin
        if (break_req[c]) begin
          m_st[c] = 2; m_combo[c] = random_hex; m_age[c] = 0;
        end
      end else begin
        if (BtnR || (BtnU && int'(sel) == c && hex_combo == m_combo[c])) begin
          m_st[c] = 1;
        end else begin
          if (BtnU && int'(sel) == c) w = 1;
          m_age[c]++;
          if (m_age[c] >= TO - 1) m_fail[c] = 1;
        end
      end
    end
    m_wrong = w;
  endtask

  task automatic compare_all(input string tag);
    logic [NCH-1:0] e_brk, e_fail, e_i, e_w, e_r;
    logic [NCH*CW-1:0] e_combo;
    int cnt;
    cnt = 0;
    for (int c = 0; c < NCH; c++) begin
      e_i[c] = (m_st[c] == 0);
      e_w[c] = (m_st[c] == 1);
      e_r[c] = (m_st[c] == 2);
      e_brk[c] = e_r[c];
      e_fail[c] = m_fail[c];
      e_combo[c*CW +: CW] = m_combo[c];
      if (e_r[c]) cnt++;
    end
    chk({tag, ".broken"}, broken, e_brk);
    chk({tag, ".combo"}, combo, e_combo);
    chk({tag, ".fail"}, fail, e_fail);
    chk({tag, ".wrong"}, wrong_attempt, m_wrong);
    chk({tag, ".count"}, broken_count, cnt);
    chk({tag, ".qinit"}, q_Init, e_i);
    chk({tag, ".qwork"}, q_Working, e_w);
    chk({tag, ".qrep"}, q_Repair, e_r);
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    break_req = '0; BtnU = 0; BtnR = 0; gameover_ctrl = 0;
  endtask

  initial begin
    Reset_n = 0; play_flag = 0; gameover_ctrl = 0; break_req = '0;
    random_hex = '0; hex_combo = '0; sel = '0; BtnU = 0; BtnR = 0;
    model_reset();
    #12;
    compare_all("reset");
    Reset_n = 1;

    // Start the game, then break channel 1 with combo A
    play_flag = 1;
    tick("play");
    break_req = 4'b0010; random_hex = 4'hA;
    tick("brk1");
    chk("t038_broken", broken, 4'b0010);
    chk("t038_combo1", combo[7:4], 4'hA);
    chk("t038_count", broken_count, 1);
    idle_inputs();

    // Wrong then correct submission on channel 1
    BtnU = 1; sel = 2'd1; hex_combo = 4'h3;
    tick("wrong");
    chk("t039_wrong", wrong_attempt, 1);
    chk("t039_still", broken[1], 1);
    BtnU = 0;
    tick("wrong_end");
    chk("t039_pulse", wrong_attempt, 0);
    BtnU = 1; hex_combo = 4'hA;
    tick("right");
    chk("t039_fixed", broken[1], 0);
    BtnU = 0;

    // Break all, then BtnR with a simultaneous wrong BtnU
    break_req = 4'b1111; random_hex = 4'h5;
    tick("brkall");
    chk("t040_count", broken_count, 4);
    break_req = '0; BtnR = 1; BtnU = 1; sel = 2'd0; hex_combo = 4'h0;
    tick("master");
    chk("t040_broken", broken, 4'b0000);
    chk("t040_wrong", wrong_attempt, 0);
    idle_inputs();

    // Timeout on channel 0 after TO-1 cycles in REPAIR
    break_req = 4'b0001; random_hex = 4'h9;
    tick("to_brk");
    break_req = '0;
    for (int k = 1; k < TO - 1; k++) begin
      tick("to_wait");
      chk("t041_nofail", fail[0], 0);
    end
    tick("to_exp");
    chk("t041_fail", fail[0], 1);
    chk("t041_stay", broken[0], 1);
    gameover_ctrl = 1;
    tick("to_go");
    chk("t041_clr", fail[0], 0);
    gameover_ctrl = 0;
    tick("to_play");
    break_req = 4'b0001; random_hex = 4'hC;
    tick("to_brk2");
    break_req = '0;
    for (int k = 1; k < TO - 1; k++) tick("to_wait2");
    BtnU = 1; sel = 2'd0; hex_combo = 4'hC;
    tick("to_race");
    chk("t041_race_fail", fail[0], 0);
    chk("t041_race_fix", broken[0], 0);
    idle_inputs();

    // Gameover from REPAIR, then an asynchronous reset mid-REPAIR
    break_req = 4'b1111; random_hex = 4'h7;
    tick("go_brk");
    break_req = '0;
    tick("go_wait");
    gameover_ctrl = 1;
    tick("go");
    chk("t042_init", q_Init, 4'b1111);
    gameover_ctrl = 0;
    tick("go_play");
    break_req = 4'b0110; random_hex = 4'hE;
    tick("rst_brk");
    break_req = '0;
    #3;
    Reset_n = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    chk("t042_rst_broken", broken, 4'b0000);
    #2;
    Reset_n = 1;
    play_flag = 0;
    tick("rst_hold");
    chk("t042_hold", q_Init, 4'b1111);
    play_flag = 1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      play_flag     = ($urandom_range(15) != 0);
      gameover_ctrl = ($urandom_range(63) == 0);
      for (int c = 0; c < NCH; c++) break_req[c] = ($urandom_range(5) == 0);
      random_hex    = CW'($urandom);
      BtnU          = ($urandom_range(3) == 0);
      BtnR          = ($urandom_range(19) == 0);
      sel           = 2'($urandom);
      hex_combo     = ($urandom_range(1) == 0) ? m_combo[sel] : CW'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
